// File: rtl/regfile_multiport.sv
// regfile_multiport: 2-read/2-write register file with same-cycle write bypass,
// a pending-write scoreboard and a sequential reload of every register from INIT_VALS.
module regfile_multiport #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter logic [DEPTH*WIDTH-1:0] INIT_VALS = '0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rd_pend0,
  output logic             rd_pend1,
  input  logic             wr_en0,
  input  logic [AW-1:0]    wr_addr0,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic             wr_en1,
  input  logic [AW-1:0]    wr_addr1,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             init_req,
  output logic             init_busy,
  output logic             wr_drop
);
  typedef enum logic {IDLE, INIT} state_t;
  state_t           r_state;
  logic [AW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic             r_drop;
  logic             w_idle, w_we0, w_we1;
  logic             w_h00, w_h01, w_h10, w_h11;
  assign w_idle = r_state == IDLE;
  assign w_we1  = w_idle & wr_en1;
  // port 1 wins an address collision, so port 0 is suppressed there
  assign w_we0  = w_idle & wr_en0 & ~(wr_en1 & (wr_addr1 == wr_addr0));
  assign w_h00  = w_we0 & (wr_addr0 == rd_addr0);
  assign w_h10  = w_we1 & (wr_addr1 == rd_addr0);
  assign w_h01  = w_we0 & (wr_addr0 == rd_addr1);
  assign w_h11  = w_we1 & (wr_addr1 == rd_addr1);
  assign rd_data0  = w_h10 ? wr_data1 : w_h00 ? wr_data0 : r_mem[rd_addr0];
  assign rd_data1  = w_h11 ? wr_data1 : w_h01 ? wr_data0 : r_mem[rd_addr1];
  assign rd_pend0  = r_pend[rd_addr0] & ~(w_h00 | w_h10);
  assign rd_pend1  = r_pend[rd_addr1] & ~(w_h01 | w_h11);
  assign init_busy = r_state == INIT;
  assign wr_drop   = r_drop;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_drop  <= 1'b0;
      r_pend  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_VALS[i*WIDTH +: WIDTH];
    end else if (r_state == IDLE) begin
      r_drop <= wr_en0 & wr_en1 & (wr_addr0 == wr_addr1);
      if (w_we0) r_mem[wr_addr0] <= wr_data0;
      if (w_we1) r_mem[wr_addr1] <= wr_data1;
      for (int i = 0; i < DEPTH; i++) begin
        if (iss_en && iss_addr == AW'(i)) r_pend[i] <= 1'b1;
        else if ((w_we0 && wr_addr0 == AW'(i)) || (w_we1 && wr_addr1 == AW'(i))) r_pend[i] <= 1'b0;
      end
      if (init_req) begin
        r_state <= INIT;
        r_ptr   <= '0;
      end
    end else begin
      r_drop <= wr_en0 | wr_en1;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_ptr == AW'(i)) begin
          r_mem[i]  <= INIT_VALS[i*WIDTH +: WIDTH];
          r_pend[i] <= 1'b0;
        end
      end
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == AW'(DEPTH-1)) begin
        r_state <= IDLE;
        r_ptr   <= '0;
      end
    end
  end
endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 The module SHALL have parameter WIDTH, default 24, meaning the data width per register in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning the register count (power of two, >=2); AW = clog2(DEPTH).
REQ-003 The module SHALL have parameter INIT_VALS, default DEPTH*WIDTH bits all zero, meaning the initial value of register i at bits [i*WIDTH +: WIDTH].
REQ-004 The module SHALL have one clock, clk (input, 1), and reset is synchronous and active-high, rst (input, 1).
REQ-005 The module SHALL have ports rd_addr0 and rd_addr1 (input, AW), the read port addresses.
REQ-006 The module SHALL have ports rd_data0 and rd_data1 (output, WIDTH), the combinational read data.
REQ-007 The module SHALL have ports rd_pend0 and rd_pend1 (output, 1), meaning the addressed register awaits a pending write.
REQ-008 The module SHALL have ports wr_en0, wr_addr0 (AW) and wr_data0 (WIDTH), all inputs, forming write port 0.
REQ-009 The module SHALL have ports wr_en1, wr_addr1 (AW) and wr_data1 (WIDTH), all inputs, forming write port 1, which has priority.
REQ-010 The module SHALL have ports iss_en (input, 1) and iss_addr (input, AW), which mark a register as pending.
REQ-011 The module SHALL have port init_req (input, 1), a request to reload all registers from INIT_VALS.
REQ-012 The module SHALL have port init_busy (output, 1), asserted while a reload is in progress.
REQ-013 The module SHALL have port wr_drop (output, 1), a one-cycle registered pulse flagging a discarded write.

Function
REQ-014 Register writes SHALL take effect at the clk edge on which wr_en is sampled high.
REQ-015 When wr_en0 and wr_en1 are both high with equal addresses in IDLE, wr_data1 SHALL be written, port 0 SHALL be discarded, and wr_drop SHALL be 1 in the next cycle.
REQ-016 Reads SHALL be combinational, with bypass: if the read address matches an active write in IDLE in the same cycle, rd_data SHALL be that write's data (port 1 before port 0), otherwise the stored value.
REQ-017 The pending bit pend[a] SHALL be set at the edge when iss_en=1 and iss_addr=a in IDLE.
REQ-018 The pending bit pend[a] SHALL be cleared at the edge when any write to a occurs in IDLE.
REQ-019 When an issue and a write hit the same address in the same cycle, the set SHALL win and pend stays 1.
REQ-020 rd_pendN SHALL equal pend[rd_addrN] AND NOT (an active write to rd_addrN in this cycle).
REQ-021 The reload FSM SHALL have two states: IDLE and INIT.
REQ-022 In IDLE, init_req=1 SHALL cause a transition to INIT at the next edge, with ptr=0 and init_busy=1 from that cycle.
REQ-023 In INIT, at each edge the module SHALL write INIT_VALS entry ptr to register ptr, clear pend[ptr] and increment ptr.
REQ-024 After the edge that writes register DEPTH-1, the FSM SHALL return to IDLE with ptr=0; a reload therefore takes exactly DEPTH cycles with init_busy=1.
REQ-025 In INIT, init_req SHALL be ignored; the reload is not restarted.
REQ-026 In INIT, any write-port request SHALL be discarded and wr_drop SHALL be 1 in the next cycle.
REQ-027 In INIT, iss_en SHALL be ignored without a flag.
REQ-028 In INIT, reads SHALL return stored contents without bypass, and rd_pend SHALL be pend[addr].
REQ-029 In all other cases wr_drop SHALL be 0.

Reset
REQ-030 At a clk edge with rst=1, all registers SHALL load INIT_VALS immediately, with pend all 0, FSM IDLE, ptr=0, init_busy=0 and wr_drop=0.
REQ-031 rst SHALL override any write, issue or reload in progress, including an INIT sequence that is mid-way.
REQ-032 Reset SHALL be synchronous: with rst=1 and no clk edge, the outputs SHALL not change.

Verification (WIDTH=24, DEPTH=16, INIT entry 0 = 0x006300, entry 1 = 0x101401, others 0)
REQ-033 Reset, then read addr 0 and addr 1 -> rd_data0=0x006300, rd_data1=0x101401, rd_pend=0, init_busy=0.
REQ-034 Write 0xABCDEF to r5 via port 0 while reading r5 in the same cycle -> rd_data=0xABCDEF in that cycle, and stored 0xABCDEF in the next cycle.
REQ-035 Same cycle: port 0 writes r3=0x111111 and port 1 writes r3=0x222222 -> r3=0x222222, wr_drop=1 for exactly one cycle.
REQ-036 Issue r7; the next cycle rd_pend=1; issue r7 and write r7=0x5 in the same cycle -> pend stays 1; a later write alone -> pend 0.
REQ-037 After modifying r0, assert init_req and also write r2 during INIT -> init_busy high for exactly 16 cycles, the r2 write is dropped with wr_drop pulsed, and afterwards all registers equal INIT_VALS.
REQ-038 Assert rst at INIT cycle 5 -> next cycle IDLE, init_busy=0, all registers equal INIT_VALS, pend all 0.
